// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU issuer/return path, the result FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the environment side.
interface alu_result_fifo_if #(
  parameter int DW = 16,
  parameter int LW = 4
);
  logic          issue;
  logic          issue_ok;
  logic          alu_valid;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_negative;
  logic          alu_overflow;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_result;
  logic          rd_zero;
  logic          rd_negative;
  logic          rd_overflow;
  logic [LW-1:0] level;
  logic [LW-1:0] in_flight;
  logic          err_drop;
  logic          err_unexp;
  logic          err_clr;

  modport slave (
    input  issue, alu_valid, alu_result, alu_zero, alu_negative, alu_overflow,
    input  rd_ready, err_clr,
    output issue_ok, rd_valid, rd_result, rd_zero, rd_negative, rd_overflow,
    output level, in_flight, err_drop, err_unexp
  );

  modport master (
    output issue, alu_valid, alu_result, alu_zero, alu_negative, alu_overflow,
    output rd_ready, err_clr,
    input  issue_ok, rd_valid, rd_result, rd_zero, rd_negative, rd_overflow,
    input  level, in_flight, err_drop, err_unexp
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU result beats, with an issue credit counter
// so the upstream issuer can avoid overrunning the queue of a non-stallable ALU.
module alu_result_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  alu_result_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DW + 3;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, infl_q, infl_d;
  logic [EW-1:0] head_q, head_d;
  logic          err_drop_q, err_drop_d, err_unexp_q, err_unexp_d;
  logic [EW-1:0] wdata;
  logic          pop, push_ok, drop, unexp;
  logic [LW:0]   credit;

  assign wdata   = {bus.alu_overflow, bus.alu_negative, bus.alu_zero, bus.alu_result};
  assign pop     = (level_q != '0) & bus.rd_ready;
  assign push_ok = bus.alu_valid & ((level_q != DEPTH_L) | pop);
  assign drop    = bus.alu_valid & ~push_ok;
  assign unexp   = bus.alu_valid & ~bus.issue & (infl_q == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    infl_d   = infl_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    // Head register always holds the entry at rd_ptr_d, or the last popped one when empty.
    if (push_ok && (level_q == '0 || (pop && level_q == ONE_L)))
      head_d = wdata;
    else if (pop && level_q > ONE_L)
      head_d = mem_q[rd_ptr_d];
    if (bus.issue && !bus.alu_valid && infl_q != DEPTH_L)
      infl_d = infl_q + 1'b1;
    else if (!bus.issue && bus.alu_valid && infl_q != '0)
      infl_d = infl_q - 1'b1;
    err_drop_d  = bus.err_clr ? 1'b0 : (err_drop_q | drop);
    err_unexp_d = bus.err_clr ? 1'b0 : (err_unexp_q | unexp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      infl_q      <= '0;
      head_q      <= '0;
      err_drop_q  <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      infl_q      <= infl_d;
      head_q      <= head_d;
      err_drop_q  <= err_drop_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  // Storage is never read before being written, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  assign credit          = {1'b0, level_q} + {1'b0, infl_q};
  assign bus.issue_ok    = credit < {1'b0, DEPTH_L};
  assign bus.rd_valid    = (level_q != '0);
  assign bus.rd_result   = head_q[DW-1:0];
  assign bus.rd_zero     = head_q[DW];
  assign bus.rd_negative = head_q[DW+1];
  assign bus.rd_overflow = head_q[DW+2];
  assign bus.level       = level_q;
  assign bus.in_flight   = infl_q;
  assign bus.err_drop    = err_drop_q;
  assign bus.err_unexp   = err_unexp_q;
endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_fifo;
  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_XOR = 3, OP_SLT = 4;

  logic clk = 1'b0;
  logic rst;
  alu_result_fifo_if #(.DW(DW), .LW(LW)) bus ();
  alu_result_fifo #(.DEPTH(DEPTH), .DW(DW), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {ovf,neg,zero,result}
  logic [18:0] mq[$];
  logic [18:0] m_last;
  int          m_infl;
  bit          m_drop, m_unexp;

  function automatic logic [18:0] alu(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      OP_SUB: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      default: r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
    return {v, r[15], (r == 16'd0), r};
  endfunction

  function automatic logic [18:0] m_head();
    return (mq.size() != 0) ? mq[0] : m_last;
  endfunction

  function automatic logic [18:0] got_head();
    return {bus.rd_overflow, bus.rd_negative, bus.rd_zero, bus.rd_result};
  endfunction

  function automatic bit m_issue_ok();
    return (mq.size() + m_infl) < DEPTH;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_last  = '0;
    m_infl  = 0;
    m_drop  = 0;
    m_unexp = 0;
  endfunction

  function automatic void model_step(input bit iss, input bit av, input logic [18:0] beat,
                                     input bit rr, input bit ec);
    int lvl;
    bit pop, dr, ux;
    lvl = mq.size();
    pop = (lvl != 0) && rr;
    dr  = 0;
    ux  = 0;
    if (pop) m_last = mq.pop_front();
    if (av) begin
      if (lvl < DEPTH || pop) mq.push_back(beat);
      else dr = 1;
    end
    if (iss && !av) m_infl = (m_infl + 1 > DEPTH) ? DEPTH : m_infl + 1;
    else if (av && !iss) begin
      if (m_infl == 0) ux = 1;
      else m_infl = m_infl - 1;
    end
    m_drop  = ec ? 1'b0 : (m_drop | dr);
    m_unexp = ec ? 1'b0 : (m_unexp | ux);
  endfunction

  task automatic cycle(input bit iss, input bit av, input logic [18:0] beat,
                       input bit rr, input bit ec);
    bus.issue     = iss;
    bus.alu_valid = av;
    {bus.alu_overflow, bus.alu_negative, bus.alu_zero, bus.alu_result} = beat;
    bus.rd_ready  = rr;
    bus.err_clr   = ec;
    @(posedge clk);
    model_step(iss, av, beat, rr, ec);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    release_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL rst_level got %0d want 0", bus.level); end
    checks++; if (bus.in_flight !== '0) begin errors++; $display("FAIL rst_in_flight got %0d want 0", bus.in_flight); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL rst_issue_ok got %b want 1", bus.issue_ok); end
    checks++; if (got_head() !== 19'h0) begin errors++; $display("FAIL rst_head got %h want 0", got_head()); end
    checks++; if ({bus.err_drop, bus.err_unexp} !== 2'b00) begin errors++; $display("FAIL rst_err got %b want 00", {bus.err_drop, bus.err_unexp}); end
  endtask

  task automatic test_add();
    cycle(1, 0, '0, 0, 0);
    checks++; if (bus.in_flight !== LW'(1)) begin errors++; $display("FAIL add_infl_issue got %0d want 1", bus.in_flight); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", bus.rd_valid); end
    cycle(0, 1, alu(OP_ADD, 16'h1234, 16'h5678), 0, 0);
    checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL add_rd_valid got %b want 1", bus.rd_valid); end
    checks++; if (got_head() !== 19'h068AC) begin errors++; $display("FAIL add_head got %h want 068ac", got_head()); end
    checks++; if (bus.level !== LW'(1) || bus.in_flight !== '0) begin errors++; $display("FAIL add_counts got lvl %0d infl %0d want 1 0", bus.level, bus.in_flight); end
    cycle(0, 0, '0, 1, 0);
    checks++; if (bus.level !== '0 || bus.rd_valid !== 1'b0) begin errors++; $display("FAIL add_pop got lvl %0d vld %b want 0 0", bus.level, bus.rd_valid); end
    checks++; if (got_head() !== 19'h068AC) begin errors++; $display("FAIL add_last got %h want 068ac", got_head()); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, '0, 0, 0);
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, alu(OP_SUB, 16'h8000, 16'h0001), 0, 0);
    cycle(0, 1, alu(OP_AND, 16'hFF00, 16'h0FF0), 0, 0);
    checks++; if (bus.level !== LW'(2)) begin errors++; $display("FAIL b2b_level got %0d want 2", bus.level); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, 0, 0);
      checks++; if (got_head() !== 19'h47FFF || bus.rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold%0d got %h vld %b want 47fff 1", i, got_head(), bus.rd_valid); end
    end
    cycle(0, 0, '0, 1, 0);
    checks++; if (got_head() !== 19'h00F00 || bus.level !== LW'(1)) begin errors++; $display("FAIL b2b_second got %h lvl %0d want 00f00 1", got_head(), bus.level); end
    cycle(0, 0, '0, 1, 0);
    checks++; if (bus.level !== '0) begin errors++; $display("FAIL b2b_drain got %0d want 0", bus.level); end
  endtask

  task automatic test_fill();
    int n = 0;
    for (int i = 0; i < 20 && bus.issue_ok; i++) begin
      cycle(1, 0, '0, 0, 0);
      n++;
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL fill_issues got %0d want %0d", n, DEPTH); end
    checks++; if (bus.in_flight !== LW'(DEPTH)) begin errors++; $display("FAIL fill_infl got %0d want %0d", bus.in_flight, DEPTH); end
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 1, alu(OP_XOR, 16'($urandom), 16'($urandom)), 0, 0);
    checks++; if (bus.level !== LW'(DEPTH) || bus.issue_ok !== 1'b0) begin errors++; $display("FAIL fill_full got lvl %0d ok %b want %0d 0", bus.level, bus.issue_ok, DEPTH); end
    cycle(0, 0, '0, 1, 0);
    checks++; if (bus.level !== LW'(DEPTH - 1) || bus.issue_ok !== 1'b1) begin errors++; $display("FAIL fill_pop got lvl %0d ok %b want %0d 1", bus.level, bus.issue_ok, DEPTH - 1); end
    checks++; if (got_head() !== m_head()) begin errors++; $display("FAIL fill_head got %h want %h", got_head(), m_head()); end
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, alu(OP_ADD, 16'h0001, 16'h0002), 0, 0);
  endtask

  task automatic test_drop();
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, alu(OP_ADD, 16'h7FFF, 16'h0001), 0, 0);
    checks++; if (bus.err_drop !== 1'b1 || bus.level !== LW'(DEPTH)) begin errors++; $display("FAIL drop_set got drop %b lvl %0d want 1 %0d", bus.err_drop, bus.level, DEPTH); end
    checks++; if (bus.err_unexp !== 1'b0) begin errors++; $display("FAIL drop_unexp got %b want 0", bus.err_unexp); end
    cycle(0, 0, '0, 0, 1);
    checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL drop_clr got %b want 0", bus.err_drop); end
    cycle(1, 1, alu(OP_AND, 16'hFFFF, 16'h1111), 0, 1);
    checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL drop_clr_prio got %b want 0", bus.err_drop); end
    cycle(1, 1, alu(OP_AND, 16'hFFFF, 16'h2222), 0, 0);
    checks++; if (bus.err_drop !== 1'b1) begin errors++; $display("FAIL drop_reset got %b want 1", bus.err_drop); end
    checks++; if (got_head() !== m_head()) begin errors++; $display("FAIL drop_head got %h want %h", got_head(), m_head()); end
  endtask

  task automatic test_wrap();
    logic [18:0] b;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) b = alu(OP_SLT, 16'hFFFF, 16'h0001);
      else if (i % 2 == 0) b = alu(OP_XOR, 16'($urandom), 16'($urandom));
      else b = alu(OP_SLT, 16'($urandom), 16'($urandom));
      cycle(1, 1, b, 1, 0);
      checks++; if (bus.level !== LW'(DEPTH) || got_head() !== m_head()) begin errors++; $display("FAIL wrap%0d got lvl %0d head %h want %0d %h", i, bus.level, got_head(), DEPTH, m_head()); end
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      cycle(0, 0, '0, 1, 0);
      checks++; if (got_head() !== m_head()) begin errors++; $display("FAIL wrap_drain%0d got %h want %h", i, got_head(), m_head()); end
    end
    checks++; if (got_head() !== 19'h00001 || bus.level !== LW'(1)) begin errors++; $display("FAIL wrap_slt got %h lvl %0d want 00001 1", got_head(), bus.level); end
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 1);
  endtask

  task automatic test_unexp_reset();
    do_reset();
    cycle(0, 1, alu(OP_ADD, 16'h0003, 16'h0004), 0, 0);
    checks++; if (bus.err_unexp !== 1'b1 || bus.in_flight !== '0) begin errors++; $display("FAIL unexp got %b infl %0d want 1 0", bus.err_unexp, bus.in_flight); end
    checks++; if (bus.level !== LW'(1) || got_head() !== 19'h00007) begin errors++; $display("FAIL unexp_push got lvl %0d head %h want 1 00007", bus.level, got_head()); end
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, alu(OP_SUB, 16'h0005, 16'h0005), 0, 0);
    cycle(1, 1, alu(OP_XOR, 16'hAAAA, 16'h5555), 0, 0);
    checks++; if (bus.level !== LW'(3)) begin errors++; $display("FAIL pre_rst_level got %0d want 3", bus.level); end
    #2 rst = 1'b1;
    #1;
    model_clear();
    checks++; if (bus.rd_valid !== 1'b0 || bus.level !== '0 || bus.in_flight !== '0) begin errors++; $display("FAIL async_rst got vld %b lvl %0d infl %0d want 0 0 0", bus.rd_valid, bus.level, bus.in_flight); end
    checks++; if (bus.err_unexp !== 1'b0 || got_head() !== 19'h0) begin errors++; $display("FAIL async_rst_state got unexp %b head %h want 0 0", bus.err_unexp, got_head()); end
    release_reset();
  endtask

  task automatic test_random();
    bit iss, av, rr, ec;
    for (int i = 0; i < 400; i++) begin
      iss = ($urandom_range(0, 99) < ((i < 200) ? 50 : 30)) && (bus.issue_ok || $urandom_range(0, 9) == 0);
      av  = ($urandom_range(0, 99) < ((i < 200) ? 45 : 60));
      rr  = ($urandom_range(0, 99) < ((i < 200) ? 25 : 60));
      ec  = ($urandom_range(0, 15) == 0);
      cycle(iss, av, alu($urandom_range(0, 4), 16'($urandom), 16'($urandom)), rr, ec);
      checks++; if (int'(bus.level) !== mq.size() || bus.rd_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_level%0d got %0d vld %b want %0d", i, bus.level, bus.rd_valid, mq.size()); end
      checks++; if (int'(bus.in_flight) !== m_infl || bus.issue_ok !== m_issue_ok()) begin errors++; $display("FAIL rnd_credit%0d got %0d ok %b want %0d %b", i, bus.in_flight, bus.issue_ok, m_infl, m_issue_ok()); end
      checks++; if (got_head() !== m_head()) begin errors++; $display("FAIL rnd_head%0d got %h want %h", i, got_head(), m_head()); end
      checks++; if (bus.err_drop !== m_drop || bus.err_unexp !== m_unexp) begin errors++; $display("FAIL rnd_err%0d got %b%b want %b%b", i, bus.err_drop, bus.err_unexp, m_drop, m_unexp); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.issue = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_result = '0;
    bus.alu_zero = 1'b0;
    bus.alu_negative = 1'b0;
    bus.alu_overflow = 1'b0;
    bus.rd_ready = 1'b0;
    bus.err_clr = 1'b0;
    model_clear();
    test_reset();
    test_add();
    test_back_to_back();
    test_fill();
    test_drop();
    test_wrap();
    test_unexp_reset();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
Consumer-side buffer for alu_pipeline. It captures each result/flag beat that the ALU emits on its valid_out strobe and queues it in a first-word-fall-through FIFO behind a valid/ready read port. alu_pipeline cannot be back-pressured, so the block also keeps a credit count of issued-but-not-returned operations. Its issue_ok output lets the upstream command issuer avoid overrunning the FIFO.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=2)
DW, 16, ALU result width
LW, $clog2(DEPTH+1), width of level and in_flight counters

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
issue  input  1  high for one cycle per op driven into the ALU (same signal as ALU valid_in)
issue_ok  output  1  upstream may assert issue this cycle
alu_valid  input  1  ALU valid_out
alu_result  input  DW  ALU result
alu_zero  input  1  ALU zero flag
alu_negative  input  1  ALU negative flag
alu_overflow  input  1  ALU overflow flag
rd_valid  output  1  head entry available
rd_ready  input  1  consumer accepts head
rd_result  output  DW  head result
rd_zero  output  1  head zero flag
rd_negative  output  1  head negative flag
rd_overflow  output  1  head overflow flag
level  output  LW  entries stored, 0..DEPTH
in_flight  output  LW  ops issued, not yet returned, 0..DEPTH
err_drop  output  1  sticky: a beat arrived while the FIFO was full and was dropped
err_unexp  output  1  sticky: alu_valid arrived while in_flight==0
err_clr  input  1  clears both sticky error bits

Behaviour:
- Reset (async assert, release synchronous to clk): level=0, in_flight=0, read/write pointers=0, rd_valid=0, rd_result/flags=0, err_drop=0, err_unexp=0. issue_ok=1 after reset.
- Entry format: {overflow, negative, zero, result} = DW+3 bits. Stored bit-exact.
- push = alu_valid. pop = rd_valid & rd_ready.
- Push is accepted if level<DEPTH, or if level==DEPTH and pop occurs in the same cycle.
- A rejected push drops the beat, sets err_drop, and leaves level unchanged.
- FWFT read port: rd_valid = (level!=0). rd_* shows the head entry from registered storage. rd_* must be held stable while rd_valid & !rd_ready.
- When rd_valid=0, rd_* shows the last popped entry, or 0 after reset.
- No bypass path: a push into an empty FIFO becomes visible on rd_valid the cycle after alu_valid (1-cycle latency).
- Simultaneous push and pop: level unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Pop when empty is ignored, because rd_valid=0.
- in_flight next value = in_flight + issue - alu_valid, with these rules:
  - Saturates at DEPTH.
  - alu_valid with in_flight==0 (and no issue the same cycle) sets err_unexp; in_flight stays 0. The beat is still pushed.
  - issue and alu_valid in the same cycle: in_flight unchanged.
- issue_ok = (level + in_flight) < DEPTH, computed combinationally from registered counters only. The rule is conservative: a same-cycle pop is not credited.
- issue while issue_ok=0 is still counted, and the FIFO may then overflow, which is reported via err_drop.
- err_clr has priority over a same-cycle set: the bit is cleared that cycle and a new event sets it the next cycle.
- rst asserted mid-operation discards all queued entries and in-flight credit immediately. ALU beats returning after reset release count as unexpected.
- No combinational path from rd_ready to issue_ok or rd_valid.

Test Plan:
- Issue ADD a=0x1234, b=0x5678. When alu_valid returns, check rd_valid=1 the next cycle with rd_result=0x68AC and zero/negative/overflow=0/0/0. With rd_ready=1: level goes 1->0 and in_flight goes 1->0.
- Back-to-back SUB 0x8000-0x0001, then AND 0xFF00&0x0FF0, with rd_ready=0. Expect two entries in order: {0x7FFF, ovf=1, neg=0} then {0x0F00, 0,0,0}; level=2. Hold rd_ready=0 for 5 cycles and check rd_* stable.
- DEPTH=8, rd_ready=0: issue until issue_ok drops. Expect exactly 8 issues accepted and level=8 after returns. Then rd_ready=1 for one cycle gives level=7 and issue_ok=1.
- With level=8: force alu_valid while rd_ready=0. Expect err_drop=1 next cycle and level=8. Pulse err_clr: err_drop=0.
- With level=8: alu_valid and rd_ready together. Expect the beat accepted, level=8, and pointer wrap with no data corruption over 20 mixed XOR/SLT ops; SLT 0xFFFF vs 0x0001 returns rd_result=0x0001.
- Inject alu_valid with in_flight=0 and expect err_unexp=1. Assert rst with 3 entries queued: rd_valid=0, level=0, in_flight=0 asynchronously.
